gb_timer: RTL and testbench
===========================

Name: gb_timer

Overview:
- Game Boy DIV/TIMA/TMA/TAC timer unit, memory-mapped at FF04–FF07.
- Sits beside the CPU on the CPU memory bus. The memory map decodes the address range, routes CPU writes here, and muxes reads back using hit.
- Drives the top-level timer_int interrupt line, which the interrupt logic consumes as IF bit 2.
- Clocked on the CPU clock; one clock cycle equals one T-cycle.

Parameters:
- BASE_ADDR, 16'hFF04: address of DIV. TIMA, TMA and TAC follow at +1, +2 and +3.
- RELOAD_DELAY, 4: cycles between TIMA overflow and the TMA reload plus interrupt pulse. Legal range 1–15.

Ports:
- clock, in, 1: CPU clock. All state updates on the rising edge.
- reset, in, 1: asynchronous, active-low. The top drives it directly from KEY[0].
- cpu_addr, in, 16: CPU bus address.
- cpu_wren, in, 1: CPU write strobe, single cycle.
- cpu_data_in, in, 8: CPU write data.
- cpu_data_out, out, 8: register read data. Combinational from cpu_addr.
- hit, out, 1: high when cpu_addr is in BASE_ADDR..BASE_ADDR+3. Combinational.
- timer_int, out, 1: one-cycle interrupt request pulse on TIMA reload.

Behaviour:
- Reset (reset low, asynchronous):
  - sys_cnt[15:0]=0, TIMA=0, TMA=0, TAC=0.
  - Reload state cleared, falling-edge detector register cleared.
  - timer_int=0.
  - Outputs are valid immediately while reset is low.
- System counter:
  - sys_cnt increments by 1 every cycle and wraps FFFF->0000.
  - DIV reads sys_cnt[15:8].
  - Any write to DIV (data ignored) sets sys_cnt to 0 on that edge.
- Tick selection from TAC[1:0]:
  - 00 selects sys_cnt[9], 01 selects [3], 10 selects [5], 11 selects [7].
  - tick_sig = TAC[2] AND selected bit, computed from the registered sys_cnt.
  - A TIMA increment occurs on a 1->0 transition of tick_sig, comparing the current value against the value registered last cycle.
  - Consequence: a DIV reset or a TAC write that drops tick_sig from 1 to 0 causes one spurious increment. This is required, hardware-accurate behaviour.
- State machine, two states:
  - COUNT: on an increment with TIMA=FF, TIMA becomes 00 and the machine enters RELOAD with delay_cnt=RELOAD_DELAY-1. Otherwise TIMA increments normally.
  - RELOAD: TIMA reads 00 and delay_cnt decrements each cycle. When delay_cnt=0: TIMA<=TMA, timer_int=1 for exactly that cycle, and the machine returns to COUNT.
  - Increments that occur in RELOAD are ignored.
- Register reads:
  - DIV=sys_cnt[15:8], TIMA, TMA.
  - TAC reads {5'b11111, TAC[2:0]}.
  - When hit=0, cpu_data_out=8'hFF.
- Writes (cpu_wren=1 with address hit) take effect on the next edge:
  - TIMA write in COUNT: the written value wins over a same-cycle increment.
  - TIMA write in RELOAD: cancels the reload. The written value is kept, timer_int does not pulse, and the machine returns to COUNT.
  - TMA write: always stored. If it coincides with the reload cycle, TIMA loads the new data_in value.
  - TAC write: stores data_in[2:0] only.
- Widths:
  - All register arithmetic is 8-bit with no carry out, except the TIMA overflow detection described above.
  - Writes with hit=0 are ignored.
- Reset asserted mid-RELOAD: abandons the reload with no interrupt pulse.

Test Plan:
1. Release reset, idle 256 cycles -> DIV reads 01, TIMA reads 00, TAC reads F8, timer_int never pulses. With address 0xC000, cpu_data_out=FF and hit=0.
2. Write TAC=05 (enabled, bit 3, period 16) and TMA=00, then write TIMA=FE -> TIMA=FF 16 cycles later and 00 16 cycles after that. timer_int pulses once, exactly RELOAD_DELAY=4 cycles after the overflow edge.
3. Set TMA=AB, TAC=04 (bit 9) and TIMA=FF, wait for overflow -> TIMA reads 00 for 4 cycles, then AB. timer_int is high for exactly one cycle.
4. During the RELOAD window of scenario 3, write TIMA=42 -> TIMA stays 42, no timer_int pulse, counting resumes from 42.
5. TAC=05. Wait until sys_cnt[3]=1, then write DIV -> sys_cnt becomes 0 and TIMA increments by exactly 1 (spurious edge). With sys_cnt[3]=0 at the time of the DIV write, TIMA is unchanged.
6. Assert reset low two cycles into RELOAD -> all registers read 0 (TAC reads F8), timer_int stays 0, and no pulse appears after reset is released.

Source files
------------

// File: rtl/gb_timer.sv
// gb_timer: DIV/TIMA/TMA/TAC timer block at BASE_ADDR..BASE_ADDR+3.
// A free-running 16-bit system counter feeds DIV and supplies the tap bit
// that clocks TIMA. TIMA overflow starts a short reload window. At the end
// of that window TIMA takes TMA and timer_int pulses for one cycle.
//
// Bus protocol: cpu_wren is a single-cycle write strobe. The write is
// accepted on the rising edge where cpu_wren=1 and cpu_addr hits this
// block. Reads have no strobe. cpu_data_out and hit follow cpu_addr
// combinationally every cycle.
module gb_timer #(
   parameter logic [15:0] BASE_ADDR    = 16'hFF04,
   parameter int unsigned RELOAD_DELAY = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] cpu_addr,
   input  logic        cpu_wren,
   input  logic [7:0]  cpu_data_in,
   output logic [7:0]  cpu_data_out,
   output logic        hit,
   output logic        timer_int
);

   // Register offsets within the four-byte window
   localparam logic [1:0] OFF_DIV  = 2'd0;
   localparam logic [1:0] OFF_TIMA = 2'd1;
   localparam logic [1:0] OFF_TMA  = 2'd2;
   localparam logic [1:0] OFF_TAC  = 2'd3;

   // Reload countdown start value: the countdown ends RELOAD_DELAY edges after overflow
   localparam logic [3:0] DELAY_INIT = 4'(RELOAD_DELAY - 1);

   typedef enum logic {
      ST_COUNT  = 1'b0,
      ST_RELOAD = 1'b1
   } state_t;

   logic [15:0] sys_cnt;
   logic [7:0]  tima;
   logic [7:0]  tma;
   logic [2:0]  tac;
   logic        tick_prev;
   logic [3:0]  delay_cnt;
   state_t      state;

   logic [15:0] addr_off;
   logic [1:0]  reg_sel;
   logic        wr_hit;
   logic        wr_div;
   logic        wr_tima;
   logic        wr_tma;
   logic        wr_tac;
   logic        tap_bit;
   logic        tick_sig;
   logic        tima_inc;

   // Address decode: offset from the base address, in range when below 4
   always_comb begin
      addr_off = cpu_addr - BASE_ADDR;
      hit      = (addr_off < 16'd4);
      reg_sel  = addr_off[1:0];
   end

   // Write strobes, one per register, only when the bus targets this block
   always_comb begin
      wr_hit  = cpu_wren & hit;
      wr_div  = wr_hit & (reg_sel == OFF_DIV);
      wr_tima = wr_hit & (reg_sel == OFF_TIMA);
      wr_tma  = wr_hit & (reg_sel == OFF_TMA);
      wr_tac  = wr_hit & (reg_sel == OFF_TAC);
   end

   // Register read mux; unmapped addresses float high like an open bus
   always_comb begin
      cpu_data_out = 8'hFF;
      if (hit) begin
         case (reg_sel)
            OFF_DIV:  cpu_data_out = sys_cnt[15:8];
            OFF_TIMA: cpu_data_out = tima;
            OFF_TMA:  cpu_data_out = tma;
            default:  cpu_data_out = {5'b11111, tac};
         endcase
      end
   end

   // Tap selection from TAC[1:0] on the registered system counter
   always_comb begin
      case (tac[1:0])
         2'b00:   tap_bit = sys_cnt[9];
         2'b01:   tap_bit = sys_cnt[3];
         2'b10:   tap_bit = sys_cnt[5];
         default: tap_bit = sys_cnt[7];
      endcase
      tick_sig = tac[2] & tap_bit;
      // A falling edge of the gated tap is a TIMA increment request. A DIV
      // reset or a TAC change that drops tick_sig also counts, as on hardware.
      tima_inc = tick_prev & ~tick_sig;
   end

   // System counter: free-running, cleared by any DIV write
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sys_cnt <= 16'h0000;
      end else if (wr_div) begin
         sys_cnt <= 16'h0000;
      end else begin
         sys_cnt <= sys_cnt + 16'h0001;
      end
   end

   // Falling-edge detector history for tick_sig
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         tick_prev <= 1'b0;
      end else begin
         tick_prev <= tick_sig;
      end
   end

   // TMA holds the reload value and is always written when addressed
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         tma <= 8'h00;
      end else if (wr_tma) begin
         tma <= cpu_data_in;
      end
   end

   // TAC keeps only the enable and clock-select bits
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         tac <= 3'b000;
      end else if (wr_tac) begin
         tac <= cpu_data_in[2:0];
      end
   end

   // TIMA counter and reload sequencer with a registered interrupt pulse
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= ST_COUNT;
         tima      <= 8'h00;
         delay_cnt <= 4'h0;
         timer_int <= 1'b0;
      end else begin
         timer_int <= 1'b0;
         case (state)
            ST_COUNT: begin
               if (wr_tima) begin
                  // CPU write wins over a same-cycle increment
                  tima <= cpu_data_in;
               end else if (tima_inc) begin
                  if (tima == 8'hFF) begin
                     tima      <= 8'h00;
                     delay_cnt <= DELAY_INIT;
                     state     <= ST_RELOAD;
                  end else begin
                     tima <= tima + 8'h01;
                  end
               end
            end
            ST_RELOAD: begin
               // TIMA holds 00 here and increment requests are dropped
               if (wr_tima) begin
                  // A CPU write aborts the pending reload and its interrupt
                  tima  <= cpu_data_in;
                  state <= ST_COUNT;
               end else if (delay_cnt == 4'h0) begin
                  // A TMA write landing on the reload edge supplies the value
                  tima      <= wr_tma ? cpu_data_in : tma;
                  timer_int <= 1'b1;
                  state     <= ST_COUNT;
               end else begin
                  delay_cnt <= delay_cnt - 4'h1;
               end
            end
            default: begin
               state <= ST_COUNT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gb_timer.sv
// tb_gb_timer: directed scenarios plus randomized bus traffic for gb_timer,
// checked against a cycle-level reference model of the timer rules.
module tb_gb_timer;

   localparam logic [15:0] BASE   = 16'hFF04;
   localparam logic [15:0] A_DIV  = 16'hFF04;
   localparam logic [15:0] A_TIMA = 16'hFF05;
   localparam logic [15:0] A_TMA  = 16'hFF06;
   localparam logic [15:0] A_TAC  = 16'hFF07;
   localparam int          RD     = 4;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] cpu_addr = 16'hFF04;
   logic        cpu_wren = 1'b0;
   logic [7:0]  cpu_data_in = 8'h00;
   logic [7:0]  cpu_data_out;
   logic        hit;
   logic        timer_int;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int pulse_cnt = 0;

   // Reference model state
   int m_sys, m_tima, m_tma, m_tac, m_since;
   bit m_prev, m_int;
   int sel_pos[4] = '{9, 3, 5, 7};

   gb_timer #(.BASE_ADDR(BASE), .RELOAD_DELAY(RD)) dut (
      .clock       (clock),
      .reset       (reset),
      .cpu_addr    (cpu_addr),
      .cpu_wren    (cpu_wren),
      .cpu_data_in (cpu_data_in),
      .cpu_data_out(cpu_data_out),
      .hit         (hit),
      .timer_int   (timer_int)
   );

   // Clock
   always #5 clock = ~clock;

   // ---------------- reference model ----------------
   function automatic void model_reset();
      m_sys = 0; m_tima = 0; m_tma = 0; m_tac = 0;
      m_since = -1; m_prev = 0; m_int = 0;
   endfunction

   function automatic bit model_hit(logic [15:0] a);
      return (int'(a) >= int'(BASE)) && (int'(a) <= int'(BASE) + 3);
   endfunction

   function automatic logic [7:0] exp_read(logic [15:0] a);
      int off;
      if (!model_hit(a)) return 8'hFF;
      off = int'(a) - int'(BASE);
      case (off)
         0:       return 8'((m_sys / 256) % 256);
         1:       return 8'(m_tima);
         2:       return 8'(m_tma);
         default: return 8'(248 + m_tac);
      endcase
   endfunction

   // One rising edge of the timer as described by its rules
   function automatic void model_step(bit wr, logic [15:0] a, logic [7:0] d);
      bit tick_now, fell, w;
      int off;
      tick_now = ((m_tac / 4) % 2 == 1) && (((m_sys >> sel_pos[m_tac % 4]) % 2) == 1);
      fell     = m_prev && !tick_now;
      m_prev   = tick_now;
      w        = wr && model_hit(a);
      off      = int'(a) - int'(BASE);
      m_int    = 0;
      if (w && off == 0) m_sys = 0;
      else m_sys = (m_sys + 1) % 65536;
      if (m_since >= 0) begin
         if (w && off == 1) begin
            m_tima  = int'(d);
            m_since = -1;
         end else begin
            m_since = m_since + 1;
            if (m_since == RD) begin
               m_tima  = (w && off == 2) ? int'(d) : m_tma;
               m_int   = 1;
               m_since = -1;
            end
         end
      end else if (w && off == 1) begin
         m_tima = int'(d);
      end else if (fell) begin
         if (m_tima == 255) begin
            m_tima  = 0;
            m_since = 0;
         end else begin
            m_tima = m_tima + 1;
         end
      end
      if (w && off == 2) m_tma = int'(d);
      if (w && off == 3) m_tac = int'(d) % 8;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic tick_once();
      @(posedge clock);
      if (reset) model_step(cpu_wren, cpu_addr, cpu_data_in);
      #1;
      cyc++;
      if (timer_int === 1'b1) pulse_cnt++;
      n_checks++;
      if (timer_int !== m_int) begin
         n_fail++;
         $display("FAIL cyc_int @%0d: got %b expected %b", cyc, timer_int, m_int);
      end
      n_checks++;
      if (cpu_data_out !== exp_read(cpu_addr)) begin
         n_fail++;
         $display("FAIL cyc_read @%0d addr %h: got %h expected %h", cyc, cpu_addr, cpu_data_out, exp_read(cpu_addr));
      end
      n_checks++;
      if (hit !== model_hit(cpu_addr)) begin
         n_fail++;
         $display("FAIL cyc_hit @%0d addr %h: got %b expected %b", cyc, cpu_addr, hit, model_hit(cpu_addr));
      end
   endtask

   task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
      cpu_addr    = a;
      cpu_data_in = d;
      cpu_wren    = 1'b1;
      tick_once();
      cpu_wren    = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick_once();
   endtask

   // Read a register between edges and compare with a constant
   task automatic peek(input string name, input logic [15:0] a, input logic [7:0] exp);
      cpu_addr = a;
      #1;
      n_checks++;
      if (cpu_data_out !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, cpu_data_out, exp);
      end
   endtask

   // Clock until TIMA reads val, with a bound; returns found flag
   task automatic wait_tima(input string name, input logic [7:0] val, input int limit, output bit found);
      cpu_addr = A_TIMA;
      found = 0;
      for (int i = 0; i < limit && !found; i++) begin
         tick_once();
         if (cpu_data_out === val) found = 1;
      end
      n_checks++;
      if (!found) begin
         n_fail++;
         $display("FAIL %s: TIMA never reached %h within %0d cycles (last %h)", name, val, limit, cpu_data_out);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      bit f;
      model_reset();
      reset = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      n_checks++;
      if (timer_int !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_int: got %b expected 0", timer_int);
      end
      peek("reset_div", A_DIV, 8'h00);
      peek("reset_tac", A_TAC, 8'hF8);
      reset = 1'b1;
      pulse_cnt = 0;
      cpu_addr = A_DIV;
      idle(256);
      peek("idle_div", A_DIV, 8'h01);
      peek("idle_tima", A_TIMA, 8'h00);
      peek("idle_tac", A_TAC, 8'hF8);
      peek("idle_unmapped", 16'hC000, 8'hFF);
      n_checks++;
      if (hit !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_hit: got %b expected 0", hit);
      end
      n_checks++;
      if (pulse_cnt != 0) begin
         n_fail++;
         $display("FAIL idle_pulses: got %0d expected 0", pulse_cnt);
      end
      f = 0;
   endtask

   task automatic test_overflow();
      bit f;
      int c_ff, c_00, c_int;
      bus_write(A_TAC, 8'h05);
      bus_write(A_TMA, 8'h00);
      bus_write(A_TIMA, 8'hFE);
      pulse_cnt = 0;
      wait_tima("ovf_ff", 8'hFF, 40, f);
      c_ff = cyc;
      wait_tima("ovf_00", 8'h00, 40, f);
      c_00 = cyc;
      n_checks++;
      if (c_00 - c_ff != 16) begin
         n_fail++;
         $display("FAIL ovf_period: got %0d cycles expected 16", c_00 - c_ff);
      end
      c_int = -1;
      for (int i = 0; i < 20 && c_int < 0; i++) begin
         tick_once();
         if (timer_int === 1'b1) c_int = cyc;
      end
      n_checks++;
      if (c_int - c_00 != RD) begin
         n_fail++;
         $display("FAIL ovf_int_delay: got %0d expected %0d", c_int - c_00, RD);
      end
      idle(10);
      n_checks++;
      if (pulse_cnt != 1) begin
         n_fail++;
         $display("FAIL ovf_pulse_count: got %0d expected 1", pulse_cnt);
      end
   endtask

   task automatic test_reload();
      bit f;
      bus_write(A_TMA, 8'hAB);
      bus_write(A_TAC, 8'h04);
      bus_write(A_TIMA, 8'hFF);
      pulse_cnt = 0;
      wait_tima("reload_ovf", 8'h00, 1100, f);
      for (int k = 1; k <= RD + 1; k++) begin
         tick_once();
         n_checks++;
         if (cpu_data_out !== ((k >= RD) ? 8'hAB : 8'h00)) begin
            n_fail++;
            $display("FAIL reload_tima k=%0d: got %h expected %h", k, cpu_data_out, (k >= RD) ? 8'hAB : 8'h00);
         end
         n_checks++;
         if (timer_int !== (k == RD)) begin
            n_fail++;
            $display("FAIL reload_int k=%0d: got %b expected %b", k, timer_int, (k == RD));
         end
      end
      n_checks++;
      if (pulse_cnt != 1) begin
         n_fail++;
         $display("FAIL reload_pulse_count: got %0d expected 1", pulse_cnt);
      end
   endtask

   task automatic test_cancel();
      bit f;
      bus_write(A_TIMA, 8'hFF);
      pulse_cnt = 0;
      wait_tima("cancel_ovf", 8'h00, 1100, f);
      tick_once();
      bus_write(A_TIMA, 8'h42);
      peek("cancel_tima", A_TIMA, 8'h42);
      idle(RD + 2);
      peek("cancel_hold", A_TIMA, 8'h42);
      wait_tima("cancel_resume", 8'h43, 1100, f);
      n_checks++;
      if (pulse_cnt != 0) begin
         n_fail++;
         $display("FAIL cancel_pulses: got %0d expected 0", pulse_cnt);
      end
   endtask

   task automatic test_div_spurious();
      bit f;
      bus_write(A_TAC, 8'h05);
      // bit 3 high at the DIV write: one spurious increment
      f = 0;
      for (int i = 0; i < 64 && !f; i++) begin
         tick_once();
         if (m_sys % 16 == 8) f = 1;
      end
      bus_write(A_TIMA, 8'h10);
      bus_write(A_DIV, 8'h5A);
      peek("div_hi_div", A_DIV, 8'h00);
      cpu_addr = A_TIMA;
      idle(3);
      peek("div_hi_tima", A_TIMA, 8'h11);
      // bit 3 low at the DIV write: no increment
      f = 0;
      for (int i = 0; i < 64 && !f; i++) begin
         tick_once();
         if (m_sys % 16 == 2) f = 1;
      end
      bus_write(A_TIMA, 8'h20);
      bus_write(A_DIV, 8'hA5);
      cpu_addr = A_TIMA;
      idle(3);
      peek("div_lo_tima", A_TIMA, 8'h20);
   endtask

   task automatic test_reset_mid_reload();
      bit f;
      bus_write(A_TMA, 8'hAB);
      bus_write(A_TIMA, 8'hFF);
      wait_tima("rst_ovf", 8'h00, 40, f);
      idle(2);
      reset = 1'b0;
      model_reset();
      #1;
      n_checks++;
      if (timer_int !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_int: got %b expected 0", timer_int);
      end
      peek("rst_tima", A_TIMA, 8'h00);
      peek("rst_tma", A_TMA, 8'h00);
      peek("rst_div", A_DIV, 8'h00);
      peek("rst_tac", A_TAC, 8'hF8);
      pulse_cnt = 0;
      idle(2);
      reset = 1'b1;
      cpu_addr = A_TIMA;
      idle(20);
      n_checks++;
      if (pulse_cnt != 0) begin
         n_fail++;
         $display("FAIL rst_pulses: got %0d expected 0", pulse_cnt);
      end
   endtask

   task automatic test_random();
      int r;
      bus_write(A_TAC, 8'h05);
      for (int i = 0; i < 4000; i++) begin
         r = int'($urandom_range(0, 15));
         cpu_addr    = (r == 0) ? 16'hC000 : 16'(int'(BASE) + int'($urandom_range(0, 4)));
         cpu_data_in = (r < 6) ? 8'(255 - int'($urandom_range(0, 3))) : 8'($urandom);
         if (cpu_addr == A_TAC && r < 12) cpu_data_in = {5'b00001, 1'b1, 2'($urandom_range(1, 3))};
         cpu_wren    = ($urandom_range(0, 9) == 0);
         tick_once();
         cpu_wren    = 1'b0;
      end
   endtask

   initial begin
      test_reset();
      test_overflow();
      test_reload();
      test_cancel();
      test_div_spurious();
      test_reset_mid_reload();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
